// File: rtl/mem_write_scoreboard.sv
// mem_write_scoreboard: watches a processor's data-memory store bus and checks
// each observed store, in order, against a preloaded table of expected
// (address, data) pairs. It counts passes and fails, latches the index of the
// first failing entry, flags writes after the table is consumed, flags loads
// into a full table, and reports a stall when no store arrives for TIMEOUT
// cycles. state_dbg exposes the FSM state (0 IDLE, 1 CHECK, 2 DONE,
// 3 TIMED_OUT) for observation.
module mem_write_scoreboard #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = $clog2(DEPTH) + 1,
  parameter int TIMEOUT   = 1000,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              arm,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              error,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic              extra_write,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    DONE      = 2'd2,
    TIMED_OUT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             extra_q, extra_d;
  logic             ovf_q, ovf_d;
  logic             prev_mw_q;

  logic [ADDR_W-1:0] tbl_addr [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];

  logic             ev;
  logic             tbl_full;
  logic             tbl_we;
  logic             hit;
  logic [CNT_W-1:0] fill_cnt;

  // Edge mode counts a store burst once; level mode counts every high cycle.
  assign ev       = EDGE_MODE ? (memwrite & ~prev_mw_q) : memwrite;
  assign tbl_full = (wr_ptr_q == CNT_W'(DEPTH));
  assign tbl_we   = (state_q == IDLE) && load_en && !tbl_full;
  // A load in the arm cycle still belongs to this run, so arm sees it.
  assign fill_cnt = wr_ptr_q + CNT_W'(tbl_we);
  assign hit      = (dataadr   == tbl_addr[rd_ptr_q[IDX_W-1:0]]) &&
                    (writedata == tbl_data[rd_ptr_q[IDX_W-1:0]]);

  // Expected-entry table; contents need no reset because wr_ptr bounds use.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_addr[wr_ptr_q[IDX_W-1:0]] <= load_addr;
      tbl_data[wr_ptr_q[IDX_W-1:0]] <= load_data;
    end
  end

  // State, pointers, counters and flags register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ffi_q     <= '1;
      timer_q   <= '0;
      extra_q   <= 1'b0;
      ovf_q     <= 1'b0;
      prev_mw_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ffi_q     <= ffi_d;
      timer_q   <= timer_d;
      extra_q   <= extra_d;
      ovf_q     <= ovf_d;
      prev_mw_q <= memwrite;
    end
  end

  // Next-state logic: loading/arming in IDLE, ordered compare in CHECK.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ffi_d    = ffi_q;
    timer_d  = timer_q;
    extra_d  = extra_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          if (tbl_full) ovf_d = 1'b1;
          else          wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
        if (arm) begin
          rd_ptr_d = '0;
          timer_d  = '0;
          state_d  = (fill_cnt == '0) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (ev) begin
          timer_d = '0;
          if (hit) begin
            pass_d = pass_q + CNT_W'(1);
          end else begin
            fail_d = fail_q + CNT_W'(1);
            if (ffi_q == '1) ffi_d = rd_ptr_q;
          end
          rd_ptr_d = rd_ptr_q + CNT_W'(1);
          if (rd_ptr_d == wr_ptr_q) state_d = DONE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = TIMED_OUT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        if (ev) extra_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy           = (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign timeout        = (state_q == TIMED_OUT);
  assign error          = (fail_q != '0) | extra_q | ovf_q | timeout;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign extra_write    = extra_q;
  assign overflow       = ovf_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Testbench for mem_write_scoreboard: two instances (edge mode and level mode)
// share one stimulus stream; a queue-based reference model predicts both.
module tb_mem_write_scoreboard;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TO    = 20;
  localparam logic [31:0] NONE_IDX = 32'((1 << CW) - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load_en, arm, memwrite;
  logic [AW-1:0] load_addr, dataadr;
  logic [DW-1:0] load_data, writedata;

  logic          busy [2], done [2], tmo [2], err [2], extra [2], ovf [2];
  logic [CW-1:0] pass_c [2], fail_c [2], ffi [2];
  logic [1:0]    state_dbg [2];

  mem_write_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .arm(arm), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy[0]), .done(done[0]), .timeout(tmo[0]), .error(err[0]),
    .pass_cnt(pass_c[0]), .fail_cnt(fail_c[0]), .first_fail_idx(ffi[0]),
    .extra_write(extra[0]), .overflow(ovf[0]), .state_dbg(state_dbg[0]));

  mem_write_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .arm(arm), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy[1]), .done(done[1]), .timeout(tmo[1]), .error(err[1]),
    .pass_cnt(pass_c[1]), .fail_cnt(fail_c[1]), .first_fail_idx(ffi[1]),
    .extra_write(extra[1]), .overflow(ovf[1]), .state_dbg(state_dbg[1]));

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;

  localparam int M_IDLE = 0, M_CHECK = 1, M_DONE = 2, M_TMO = 3;
  logic [AW+DW-1:0] exp_q[$];
  int m_st [2], m_rd [2], m_pass [2], m_fail [2], m_ffi [2], m_timer [2];
  bit m_extra [2];
  bit m_ovf  = 1'b0;
  bit m_prev = 1'b0;

  logic [31:0] tbl_a [4] = '{32'h50, 32'h54, 32'h58, 32'h5c};
  logic [31:0] tbl_d [4] = '{32'h7, 32'h7, 32'h4e, 32'h99};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit ev [2];
    ev[0] = memwrite && !m_prev;
    ev[1] = memwrite;
    if (reset) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_st[m] = M_IDLE; m_rd[m] = 0; m_pass[m] = 0; m_fail[m] = 0;
        m_ffi[m] = -1; m_timer[m] = 0; m_extra[m] = 1'b0;
      end
      return;
    end
    if (m_st[0] == M_IDLE && load_en) begin
      if (exp_q.size() == DEPTH) m_ovf = 1'b1;
      else exp_q.push_back({load_addr, load_data});
    end
    for (int m = 0; m < 2; m++) begin
      case (m_st[m])
        M_IDLE: if (arm) begin
          m_rd[m] = 0; m_timer[m] = 0;
          m_st[m] = (exp_q.size() == 0) ? M_DONE : M_CHECK;
        end
        M_CHECK: begin
          if (ev[m]) begin
            m_timer[m] = 0;
            if ({dataadr, writedata} == exp_q[m_rd[m]]) m_pass[m]++;
            else begin
              m_fail[m]++;
              if (m_ffi[m] < 0) m_ffi[m] = m_rd[m];
            end
            m_rd[m]++;
            if (m_rd[m] == exp_q.size()) m_st[m] = M_DONE;
          end else if (m_timer[m] == TO - 1) m_st[m] = M_TMO;
          else m_timer[m]++;
        end
        M_DONE: if (ev[m]) m_extra[m] = 1'b1;
        default: ;
      endcase
    end
    m_prev = memwrite;
  endtask

  task automatic compare_model();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d busy", m),  32'(busy[m]),  32'(m_st[m] == M_CHECK));
      check($sformatf("m%0d done", m),  32'(done[m]),  32'(m_st[m] == M_DONE));
      check($sformatf("m%0d tmo", m),   32'(tmo[m]),   32'(m_st[m] == M_TMO));
      check($sformatf("m%0d pass", m),  32'(pass_c[m]), 32'(m_pass[m]));
      check($sformatf("m%0d fail", m),  32'(fail_c[m]), 32'(m_fail[m]));
      check($sformatf("m%0d ffi", m),   32'(ffi[m]), (m_ffi[m] < 0) ? NONE_IDX : 32'(m_ffi[m]));
      check($sformatf("m%0d extra", m), 32'(extra[m]), 32'(m_extra[m]));
      check($sformatf("m%0d ovf", m),   32'(ovf[m]),   32'(m_ovf));
      check($sformatf("m%0d error", m), 32'(err[m]),
            32'(m_fail[m] != 0 || m_extra[m] || m_ovf || m_st[m] == M_TMO));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; load_en = 1'b0; arm = 1'b0; memwrite = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_entry(input logic [31:0] a, input logic [31:0] d, input bit with_arm);
    load_en = 1'b1; load_addr = a; load_data = d; arm = with_arm;
    tick();
    load_en = 1'b0; arm = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    int         n_load;
    int         n_wr;
    logic [3:0] bad;
    int         gap;
    int         e_pass;
    int         e_fail;
    int         e_ffi;
    bit         e_done;
    bit         e_err;
    bit         e_extra;
    bit         e_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int last;
    logic [31:0] a, d;
    do_reset();
    for (int i = 0; i < v.n_load; i++) load_entry(tbl_a[i % 4], tbl_d[i % 4], 1'b0);
    do_arm();
    if (v.n_load == 0)
      for (int m = 0; m < 2; m++) check($sformatf("%s m%0d done after arm", v.name, m), 32'(done[m]), 32'd1);
    last = (v.n_load > DEPTH ? DEPTH : v.n_load) - 1;
    for (int w = 0; w < v.n_wr; w++) begin
      idle_ticks(v.gap - 1);
      if (w < 4) begin a = tbl_a[w]; d = tbl_d[w] + (v.bad[w] ? 32'd1 : 32'd0); end
      else begin a = 32'h60; d = 32'h0; end
      if (w == last)
        for (int m = 0; m < 2; m++) check($sformatf("%s m%0d done before last", v.name, m), 32'(done[m]), 32'd0);
      pulse(a, d);
      if (w == last)
        for (int m = 0; m < 2; m++) check($sformatf("%s m%0d done after last", v.name, m), 32'(done[m]), 32'd1);
    end
    idle_ticks(2);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s m%0d pass", v.name, m),  32'(pass_c[m]), 32'(v.e_pass));
      check($sformatf("%s m%0d fail", v.name, m),  32'(fail_c[m]), 32'(v.e_fail));
      check($sformatf("%s m%0d ffi", v.name, m),   32'(ffi[m]), (v.e_ffi < 0) ? NONE_IDX : 32'(v.e_ffi));
      check($sformatf("%s m%0d done", v.name, m),  32'(done[m]),  32'(v.e_done));
      check($sformatf("%s m%0d error", v.name, m), 32'(err[m]),   32'(v.e_err));
      check($sformatf("%s m%0d extra", v.name, m), 32'(extra[m]), 32'(v.e_extra));
      check($sformatf("%s m%0d ovf", v.name, m),   32'(ovf[m]),   32'(v.e_ovf));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int nl, quiet;
    bit arm_with;
    reset = 1'b1; load_en = 1'b0; arm = 1'b0; memwrite = 1'b0;
    load_addr = '0; load_data = '0; dataadr = '0; writedata = '0;

    vecs[0] = '{"happy",    3, 3, 4'b0000, 5, 3, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"mismatch", 3, 3, 4'b0010, 5, 2, 1,  1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"two_bad",  3, 3, 4'b0101, 3, 1, 2,  0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"ovf_extra",5, 5, 4'b0000, 4, 4, 0, -1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{"empty",    0, 0, 4'b0000, 1, 0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"empty_wr", 0, 1, 4'b0000, 3, 0, 0, -1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset values
    do_reset();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst m%0d state", m), 32'(state_dbg[m]), 32'd0);
      check($sformatf("rst m%0d ffi", m),   32'(ffi[m]), NONE_IDX);
      check($sformatf("rst m%0d pass", m),  32'(pass_c[m]), 32'd0);
      check($sformatf("rst m%0d error", m), 32'(err[m]), 32'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Held memwrite: edge mode compares once, level mode every cycle
    do_reset();
    for (int i = 0; i < 3; i++) load_entry(32'h50, 32'h7, 1'b0);
    do_arm();
    idle_ticks(2);
    memwrite = 1'b1; dataadr = 32'h50; writedata = 32'h7;
    idle_ticks(3);
    memwrite = 1'b0;
    tick();
    check("held edge pass", 32'(pass_c[0]), 32'd1);
    check("held edge busy", 32'(busy[0]),   32'd1);
    check("held lvl pass",  32'(pass_c[1]), 32'd3);
    check("held lvl done",  32'(done[1]),   32'd1);
    check("held lvl fail",  32'(fail_c[1]), 32'd0);

    // Timeout fires exactly TO cycles after the last write
    do_reset();
    load_entry(tbl_a[0], tbl_d[0], 1'b0);
    load_entry(tbl_a[1], tbl_d[1], 1'b0);
    do_arm();
    idle_ticks(2);
    pulse(tbl_a[0], tbl_d[0]);
    n = 0;
    while (!tmo[0] && n < 40) begin tick(); n++; end
    check("timeout latency", 32'(n), 32'(TO));
    for (int m = 0; m < 2; m++) begin
      check($sformatf("tmo m%0d timeout", m), 32'(tmo[m]),  32'd1);
      check($sformatf("tmo m%0d done", m),    32'(done[m]), 32'd0);
      check($sformatf("tmo m%0d error", m),   32'(err[m]),  32'd1);
    end

    // Load and arm together: the entry counts, so CHECK rather than DONE
    do_reset();
    load_entry(tbl_a[0], tbl_d[0], 1'b1);
    check("load+arm busy", 32'(busy[0]), 32'd1);
    check("load+arm done", 32'(done[0]), 32'd0);
    idle_ticks(1);
    pulse(tbl_a[0], tbl_d[0]);
    check("load+arm pass", 32'(pass_c[0]), 32'd1);
    check("load+arm done2", 32'(done[0]), 32'd1);

    // Reset mid-CHECK after one of three writes
    do_reset();
    for (int i = 0; i < 3; i++) load_entry(tbl_a[i], tbl_d[i] + 32'd1, 1'b0);
    do_arm();
    idle_ticks(2);
    pulse(tbl_a[0], tbl_d[0]);
    check("midrst pre fail", 32'(fail_c[0]), 32'd1);
    reset = 1'b1; arm = 1'b1; load_en = 1'b1; memwrite = 1'b1;
    tick();
    reset = 1'b0; arm = 1'b0; load_en = 1'b0; memwrite = 1'b0;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("midrst m%0d state", m), 32'(state_dbg[m]), 32'd0);
      check($sformatf("midrst m%0d busy", m),  32'(busy[m]), 32'd0);
      check($sformatf("midrst m%0d fail", m),  32'(fail_c[m]), 32'd0);
      check($sformatf("midrst m%0d ffi", m),   32'(ffi[m]), NONE_IDX);
      check($sformatf("midrst m%0d error", m), 32'(err[m]), 32'd0);
      check($sformatf("midrst m%0d ovf", m),   32'(ovf[m]), 32'd0);
    end

    // Randomized runs against the reference model
    for (int it = 0; it < 40; it++) begin
      do_reset();
      nl = $urandom_range(0, 5);
      arm_with = 1'(($urandom_range(0, 1)));
      for (int i = 0; i < nl; i++)
        load_entry(32'h50 + 32'(4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                   arm_with && (i == nl - 1));
      if (!(arm_with && nl > 0)) do_arm();
      quiet = $urandom_range(10, 60);
      for (int c = 0; c < 60; c++) begin
        memwrite  = (c < quiet) && ($urandom_range(0, 3) == 0);
        dataadr   = 32'h50 + 32'(4 * $urandom_range(0, 3));
        writedata = 32'($urandom_range(0, 3));
        load_en   = ($urandom_range(0, 15) == 0);
        load_addr = 32'($urandom);
        load_data = 32'($urandom);
        arm       = ($urandom_range(0, 15) == 0);
        tick();
      end
      memwrite = 1'b0; load_en = 1'b0; arm = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound the whole run
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_write_scoreboard.md
Name: mem_write_scoreboard

Overview:
Synthesizable, parametrised memory-write checker that sits beside the MIPS `top` on the data-memory bus (`memwrite`, `dataadr`, `writedata`). It holds a loadable table of expected (address, data) pairs and compares each observed store against the next entry in order. It also counts passes and fails, flags extra writes, and detects stalls with a timeout. This makes self-checking usable in both simulation and on-board runs, without per-program testbench edits.

Parameters:
ADDR_W, 32, width of address field
DATA_W, 32, width of data field
DEPTH, 16, number of expected entries; power of two, at least 2
CNT_W, $clog2(DEPTH)+1, width of pointers and counters
TIMEOUT, 1000, maximum cycles allowed between write events while checking
EDGE_MODE, 1, 1 = an event is a rising edge of memwrite; 0 = every cycle memwrite is high is an event

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load_en  in  1  write the expected entry at the load pointer
load_addr  in  ADDR_W  expected address
load_data  in  DATA_W  expected data
arm  in  1  start checking
memwrite  in  1  DUT memory write enable
dataadr  in  ADDR_W  DUT write address
writedata  in  DATA_W  DUT write data
busy  out  1  high while in CHECK
done  out  1  all loaded entries have been consumed
timeout  out  1  timeout has fired
error  out  1  sticky: any fail, extra write, overflow or timeout
pass_cnt  out  CNT_W  number of matched writes
fail_cnt  out  CNT_W  number of mismatched writes
first_fail_idx  out  CNT_W  index of the first failing entry; all-ones if none
extra_write  out  1  sticky: an event occurred while in DONE
overflow  out  1  sticky: load_en was asserted with the table full

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - State is IDLE.
  - All counters and pointers are 0.
  - All flags are 0.
  - first_fail_idx is all-ones.
  - prev_memwrite is 0.
  - Table contents are don't-care.
- Reset asserted mid-CHECK aborts checking immediately with the same reset values.
- Event generation:
  - EDGE_MODE=1: event = memwrite & ~prev_memwrite.
  - EDGE_MODE=0: event = memwrite.
  - prev_memwrite registers every cycle, in all states.
- State IDLE:
  - load_en writes {load_addr, load_data} at wr_ptr, then wr_ptr increments.
  - If wr_ptr==DEPTH, the write is dropped and overflow is set.
  - arm moves the FSM to CHECK, with rd_ptr=0 and the timer at 0.
  - If wr_ptr==0 at arm, the FSM goes straight to DONE.
  - load_en and arm in the same cycle: the load is performed and the entry counts toward this run.
  - Events in IDLE are ignored.
- State CHECK (busy=1):
  - An event compares dataadr and writedata against entry[rd_ptr]; both fields must match.
  - Match increments pass_cnt.
  - Mismatch increments fail_cnt; if first_fail_idx is all-ones, it latches rd_ptr.
  - rd_ptr then increments.
  - If rd_ptr+1==wr_ptr, the next state is DONE; done is asserted the cycle after the final compare.
  - An event in the same cycle as arm is not checked.
  - The timer increments each cycle without an event and clears on an event.
  - When the timer reaches TIMEOUT-1 with no event, the next state is TIMED_OUT.
  - load_en and arm are ignored.
- State DONE:
  - done=1 and is held until reset.
  - Any event sets extra_write.
- State TIMED_OUT:
  - timeout=1 and is held until reset.
  - done stays 0.
- error is the OR of: (fail_cnt!=0), extra_write, overflow, timeout.
- Latency: each compare result is visible in the counters on the cycle after the event.
- Counters never wrap: the maximum count is DEPTH, which fits in CNT_W.

Test Plan:
1. Happy path:
   - Stimulus: load (0x50,0x7), (0x54,0x7), (0x58,0x4e); arm; drive three single-cycle memwrite pulses with matching address and data, spaced 5 cycles apart.
   - Required response: pass_cnt=3, fail_cnt=0, done=1 one cycle after the third pulse, error=0.
2. Mismatch:
   - Stimulus: same table; drive the second write as (0x54,0x8).
   - Required response: pass_cnt=2, fail_cnt=1, first_fail_idx=1, error=1, done=1.
3. Edge versus level:
   - Stimulus: EDGE_MODE=1; hold memwrite high for 3 cycles with matching entry 0.
   - Required response: exactly one compare, pass_cnt=1.
   - Stimulus: same with EDGE_MODE=0.
   - Required response: 3 compares.
4. Timeout:
   - Stimulus: TIMEOUT=20; load 2 entries; arm; drive one write, then idle.
   - Required response: timeout=1 exactly 20 cycles after that write, done=0, error=1.
5. Overflow and extra write:
   - Stimulus: DEPTH=4; assert load_en 5 times.
   - Required response: overflow=1.
   - Stimulus: complete the 4 checks, then drive one more write.
   - Required response: extra_write=1.
6. Boundary cases:
   - Stimulus: arm with an empty table.
   - Required response: done=1 next cycle.
   - Stimulus: assert reset mid-CHECK after 1 of 3 writes.
   - Required response: all outputs return to their reset values, state IDLE.
